// File: rtl/fifo_rr_read_scheduler_pkg.sv
// rtl/fifo_rr_read_scheduler_pkg.sv - shared types and defaults for the FIFO round-robin read scheduler
//
// Purpose: default widths, scheduler state encoding and the position of the
// end-of-packet flag inside a FIFO entry ({eop, data}).
// Ports: none (package).

package fifo_rr_read_scheduler_pkg;

  localparam int NUM_QUEUES_DEFAULT = 4;
  localparam int DATA_WIDTH_DEFAULT = 64;
  localparam int QID_WIDTH_DEFAULT  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // The eop flag sits directly above the payload in every FIFO entry.
  function automatic int eop_bit(input int data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/fifo_rr_read_scheduler_rr_priority_select.sv
// rtl/fifo_rr_read_scheduler_rr_priority_select.sv - combinational round-robin pick of the next requester
//
// Purpose: scans req starting one past the last granted index, wrapping
// modulo NUM_QUEUES, and returns the first requester found.
// Ports:
//   req      in   NUM_QUEUES  request vector
//   last     in   QID_WIDTH   index granted most recently
//   any_req  out  1           at least one request is present
//   pick     out  QID_WIDTH   first requester after last (0 when none)

module rr_priority_select #(
  parameter int NUM_QUEUES = 4,
  parameter int QID_WIDTH  = 2
) (
  input  logic [NUM_QUEUES-1:0] req,
  input  logic [QID_WIDTH-1:0]  last,
  output logic                  any_req,
  output logic [QID_WIDTH-1:0]  pick
);

  localparam int IW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

  logic          found;
  int            idx;
  logic [IW-1:0] idx_sel;

  always_comb begin
    any_req = |req;
    pick    = '0;
    found   = 1'b0;
    idx     = 0;
    idx_sel = '0;
    for (int k = 1; k <= NUM_QUEUES; k++) begin
      idx     = (int'(last) + k) % NUM_QUEUES;
      idx_sel = IW'(idx);
      if (!found && req[idx_sel]) begin
        pick  = QID_WIDTH'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_read_scheduler.sv
// rtl/fifo_rr_read_scheduler.sv - round-robin packet read scheduler over non-fallthrough input FIFOs
//
// Purpose: grants one input FIFO per packet in round-robin order, drives its
// read enable, captures the returned words (one cycle after each read) into a
// 2-entry output buffer and streams them out tagged with the source queue.
// Ports:
//   clk        in   1                           clock
//   reset      in   1                           asynchronous active-high reset
//   in_empty   in   NUM_QUEUES                  per-FIFO empty flag
//   in_dout    in   NUM_QUEUES*(DATA_WIDTH+1)   per-FIFO registered dout, {eop, data} per slice
//   in_rd_en   out  NUM_QUEUES                  per-FIFO read enable, one-hot or zero
//   out_data   out  DATA_WIDTH                  word payload
//   out_eop    out  1                           last word of packet
//   out_queue  out  QID_WIDTH                   source queue of the word
//   out_valid  out  1                           word available
//   out_rdy    in   1                           downstream accept
//   busy       out  1                           a packet is currently granted

module fifo_rr_read_scheduler
  import fifo_rr_read_scheduler_pkg::*;
#(
  parameter int NUM_QUEUES = NUM_QUEUES_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int QID_WIDTH  = QID_WIDTH_DEFAULT
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_QUEUES-1:0]               in_empty,
  input  logic [NUM_QUEUES*(DATA_WIDTH+1)-1:0] in_dout,
  output logic [NUM_QUEUES-1:0]               in_rd_en,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                out_eop,
  output logic [QID_WIDTH-1:0]                out_queue,
  output logic                                out_valid,
  input  logic                                out_rdy,
  output logic                                busy
);

  localparam int WW    = DATA_WIDTH + 1;
  localparam int EOP   = eop_bit(DATA_WIDTH);
  // Indexing by a QID_WIDTH-bit grant covers 2**QID_WIDTH slots; unused slots
  // read as empty so a stray index can never produce a read.
  localparam int NSLOT = 1 << QID_WIDTH;

  state_t                 state, state_nxt;
  logic [QID_WIDTH-1:0]   grant, grant_nxt;
  logic [QID_WIDTH-1:0]   rr_last, rr_last_nxt;
  logic                   inflight;
  logic [1:0]             occ;
  logic [NSLOT-1:0]       rd_en;
  logic [NSLOT-1:0]       nonempty;
  logic [WW-1:0]          words [NSLOT];

  logic [WW-1:0]          ret_word;
  logic                   eop_now;
  logic                   pop;
  logic                   push;
  logic [2:0]             fill;
  logic                   slot_ok;
  logic                   arb_open;
  logic                   any_req;
  logic [QID_WIDTH-1:0]   pick;

  logic [DATA_WIDTH-1:0]  tail_data;
  logic                   tail_eop;
  logic [QID_WIDTH-1:0]   tail_queue;

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i < NUM_QUEUES) begin : g_real
      assign words[i]    = in_dout[i*WW +: WW];
      assign nonempty[i] = ~in_empty[i];
    end else begin : g_pad
      assign words[i]    = '0;
      assign nonempty[i] = 1'b0;
    end
  end

  rr_priority_select #(
    .NUM_QUEUES (NUM_QUEUES),
    .QID_WIDTH  (QID_WIDTH)
  ) u_rr_select (
    .req     (~in_empty),
    .last    (rr_last),
    .any_req (any_req),
    .pick    (pick)
  );

  // The word on dout belongs to the queue read last cycle; grant already
  // points at it, even right after a handover.
  assign ret_word = words[grant];
  assign push     = inflight;
  assign eop_now  = inflight & ret_word[EOP];
  assign pop      = out_valid & out_rdy;

  // Buffer entries committed next cycle must fit in 2 slots once the new
  // read's word lands; pop implies occ >= 1 so this never underflows.
  assign fill     = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign slot_ok  = (fill <= 3'd1);

  // A new packet may start from IDLE or in the very cycle the current
  // packet's eop word comes back, so packets follow each other with no gap.
  assign arb_open = (state == IDLE) | eop_now;

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    rr_last_nxt = rr_last;
    rd_en       = '0;
    if (arb_open) begin
      if (slot_ok && any_req) begin
        rd_en[pick] = 1'b1;
        state_nxt   = BUSY;
        grant_nxt   = pick;
        rr_last_nxt = pick;
      end else begin
        state_nxt   = IDLE;
      end
    end else if (nonempty[grant] && slot_ok) begin
      rd_en[grant] = 1'b1;
    end
  end

  assign in_rd_en = reset ? '0 : rd_en[NUM_QUEUES-1:0];
  assign busy     = (state == BUSY);
  assign out_valid = (occ != 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      rr_last  <= QID_WIDTH'(NUM_QUEUES - 1);
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_last  <= rr_last_nxt;
      inflight <= |rd_en;
    end
  end

  // Two-entry word-order buffer: head drives the outputs directly, tail holds
  // the second word while the head is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ        <= 2'd0;
      out_data   <= '0;
      out_eop    <= 1'b0;
      out_queue  <= '0;
      tail_data  <= '0;
      tail_eop   <= 1'b0;
      tail_queue <= '0;
    end else begin
      if (push && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
        out_data  <= ret_word[DATA_WIDTH-1:0];
        out_eop   <= ret_word[EOP];
        out_queue <= grant;
      end else if (pop && occ == 2'd2) begin
        out_data  <= tail_data;
        out_eop   <= tail_eop;
        out_queue <= tail_queue;
      end
      if (push && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop))) begin
        tail_data  <= ret_word[DATA_WIDTH-1:0];
        tail_eop   <= ret_word[EOP];
        tail_queue <= grant;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (occ != 2'd3 && !(push && !pop && occ == 2'd2))
        else $error("output buffer overflow");
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rr_read_scheduler.sv
// tb/tb_fifo_rr_read_scheduler.sv - self-checking bench for the FIFO round-robin read scheduler

module tb_fifo_rr_read_scheduler;

  localparam int NQ = 4;
  localparam int DW = 16;
  localparam int QW = 2;
  localparam int WW = DW + 1;

  typedef logic [WW-1:0] word_t;
  typedef struct {
    int    q;
    word_t w;
  } ent_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NQ-1:0]     in_empty;
  logic [NQ*WW-1:0]  in_dout;
  logic [NQ-1:0]     in_rd_en;
  logic [DW-1:0]     out_data;
  logic              out_eop;
  logic [QW-1:0]     out_queue;
  logic              out_valid;
  logic              out_rdy;
  logic              busy;

  always #5 clk = ~clk;

  fifo_rr_read_scheduler #(
    .NUM_QUEUES (NQ),
    .DATA_WIDTH (DW),
    .QID_WIDTH  (QW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_empty  (in_empty),
    .in_dout   (in_dout),
    .in_rd_en  (in_rd_en),
    .out_data  (out_data),
    .out_eop   (out_eop),
    .out_queue (out_queue),
    .out_valid (out_valid),
    .out_rdy   (out_rdy),
    .busy      (busy)
  );

  // Behavioural FIFOs, expected-output scoreboard and packet-level arbiter model.
  word_t         fq [NQ][$];
  word_t         dreg [NQ];
  ent_t          sb [$];
  int            owner;
  int            rr;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            lc, pops, reads;
  logic [NQ-1:0] lrd [64];
  bit            lv [64];
  bit            leop [64];
  logic [QW-1:0] lq [64];

  task automatic drive_fifos();
    for (int i = 0; i < NQ; i++) begin
      in_empty[i]          = (fq[i].size() == 0);
      in_dout[i*WW +: WW]  = dreg[i];
    end
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= NQ; k++) begin
      int idx;
      idx = (rr + k) % NQ;
      if (fq[idx].size() > 0) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NQ; i++) begin
      fq[i].delete();
      dreg[i] = '0;
    end
    sb.delete();
    owner = -1;
    rr    = NQ - 1;
    drive_fifos();
  endtask

  task automatic clear_logs();
    lc = 0; pops = 0; reads = 0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    out_rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic push_pkt(input int q, input int len);
    for (int k = 0; k < len; k++) begin
      word_t w;
      w[DW-1:0] = DW'($urandom);
      w[DW]     = (k == len - 1);
      fq[q].push_back(w);
    end
    drive_fifos();
  endtask

  // One clock cycle: observe the DUT, check reads against the round-robin
  // packet model and outputs against the scoreboard, then advance the FIFOs.
  task automatic tick();
    logic [NQ-1:0] rd;
    bit            v, rdy;
    int            q, exp_q;
    ent_t          e;
    #1;
    rd  = in_rd_en;
    v   = out_valid;
    rdy = out_rdy;
    if (lc < 64) begin
      lrd[lc] = rd; lv[lc] = v; leop[lc] = out_eop; lq[lc] = out_queue;
    end
    n_cmp++;
    if ($countones(rd) > 1) begin
      n_fail++; $display("FAIL rd_onehot: got %b required at most one bit", rd);
    end
    if (rd != '0) begin
      q = 0;
      for (int i = 0; i < NQ; i++) if (rd[i]) q = i;
      reads++;
      if (owner < 0) begin
        exp_q = rr_pick();
        n_cmp++;
        if (q != exp_q) begin
          n_fail++; $display("FAIL rr_pick: got q%0d required q%0d", q, exp_q);
        end
        owner = q;
        rr    = q;
      end else begin
        n_cmp++;
        if (q != owner) begin
          n_fail++; $display("FAIL rd_foreign: got q%0d required q%0d", q, owner);
        end
      end
      n_cmp++;
      if (fq[q].size() == 0) begin
        n_fail++; $display("FAIL rd_empty: read of q%0d got empty required non-empty", q);
      end else begin
        e.q = q;
        e.w = fq[q][0];
        sb.push_back(e);
        if (e.w[DW]) owner = -1;
      end
    end
    if (v && rdy) begin
      pops++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL out_spurious: got word %h required none", out_data);
      end else begin
        e = sb.pop_front();
        if (out_data !== e.w[DW-1:0] || out_eop !== e.w[DW] || out_queue !== QW'(e.q)) begin
          n_fail++;
          $display("FAIL out_word: got q%0d eop%0b %h required q%0d eop%0b %h",
                   out_queue, out_eop, out_data, e.q, e.w[DW], e.w[DW-1:0]);
        end
      end
    end
    n_cmp++;
    if (sb.size() > 2) begin
      n_fail++; $display("FAIL outstanding: got %0d required <= 2", sb.size());
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NQ; i++)
      if (rd[i] && fq[i].size() > 0) dreg[i] = fq[i].pop_front();
    drive_fifos();
    lc++;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    out_rdy = 1'b1;
    model_reset();
    push_pkt(1, 2);
    @(posedge clk);
    #1;
    n_cmp++; if (in_rd_en !== '0) begin n_fail++; $display("FAIL rst_rd_en: got %b required 0", in_rd_en); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h required 0", out_data); end
    n_cmp++; if (out_eop !== 1'b0) begin n_fail++; $display("FAIL rst_eop: got %b required 0", out_eop); end
    n_cmp++; if (out_queue !== '0) begin n_fail++; $display("FAIL rst_queue: got %0d required 0", out_queue); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_logs();
    repeat (6) tick();
    n_cmp++; if (lrd[0] !== 4'b0010) begin n_fail++; $display("FAIL rst_first_grant: got %b required 0010", lrd[0]); end
    n_cmp++; if (pops != 2) begin n_fail++; $display("FAIL rst_pops: got %0d required 2", pops); end
  endtask

  task automatic test_single();
    do_reset();
    out_rdy = 1'b1;
    push_pkt(0, 3);
    repeat (10) tick();
    n_cmp++;
    if (lrd[0] !== 4'b0001 || lrd[1] !== 4'b0001 || lrd[2] !== 4'b0001 || lrd[3] !== 4'b0000) begin
      n_fail++; $display("FAIL single_reads: got %b %b %b %b required 0001 0001 0001 0000", lrd[0], lrd[1], lrd[2], lrd[3]);
    end
    n_cmp++; if (reads != 3) begin n_fail++; $display("FAIL single_read_count: got %0d required 3", reads); end
    n_cmp++;
    if (lv[1] !== 1'b0 || lv[2] !== 1'b1 || lv[3] !== 1'b1 || lv[4] !== 1'b1 || lv[5] !== 1'b0) begin
      n_fail++; $display("FAIL single_valid: got %b%b%b%b%b required 01110", lv[1], lv[2], lv[3], lv[4], lv[5]);
    end
    n_cmp++;
    if (leop[2] !== 1'b0 || leop[3] !== 1'b0 || leop[4] !== 1'b1) begin
      n_fail++; $display("FAIL single_eop: got %b%b%b required 001", leop[2], leop[3], leop[4]);
    end
    n_cmp++;
    if (lq[2] !== 2'd0 || lq[3] !== 2'd0 || lq[4] !== 2'd0) begin
      n_fail++; $display("FAIL single_queue: got %0d %0d %0d required 0 0 0", lq[2], lq[3], lq[4]);
    end
  endtask

  task automatic test_fairness();
    int exp_q [8];
    exp_q = '{0, 0, 2, 2, 0, 0, 2, 2};
    do_reset();
    out_rdy = 1'b1;
    push_pkt(0, 2); push_pkt(2, 2); push_pkt(0, 2); push_pkt(2, 2);
    repeat (14) tick();
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (lrd[k] !== (NQ'(1) << exp_q[k])) begin
        n_fail++; $display("FAIL fair_read%0d: got %b required q%0d", k, lrd[k], exp_q[k]);
      end
      n_cmp++;
      if (lv[k+2] !== 1'b1 || lq[k+2] !== QW'(exp_q[k])) begin
        n_fail++; $display("FAIL fair_out%0d: got valid %b q%0d required valid 1 q%0d", k, lv[k+2], lq[k+2], exp_q[k]);
      end
    end
    n_cmp++;
    if (lrd[8] !== '0 || lv[10] !== 1'b0) begin
      n_fail++; $display("FAIL fair_tail: got rd %b valid %b required 0 0", lrd[8], lv[10]);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    push_pkt(1, 4);
    for (int k = 0; k < 16; k++) begin
      out_rdy = !(k >= 3 && k <= 6);
      tick();
    end
    out_rdy = 1'b1;
    n_cmp++;
    if (lrd[0] !== 4'b0010 || lrd[1] !== 4'b0010 || lrd[2] !== 4'b0010 || lrd[7] !== 4'b0010) begin
      n_fail++; $display("FAIL bp_reads: got %b %b %b %b required 0010 x4", lrd[0], lrd[1], lrd[2], lrd[7]);
    end
    n_cmp++;
    if ((lrd[3] | lrd[4] | lrd[5] | lrd[6]) !== '0) begin
      n_fail++; $display("FAIL bp_stall: got reads %b required none during stall", lrd[3] | lrd[4] | lrd[5] | lrd[6]);
    end
    n_cmp++;
    if (lv[3] !== 1'b1 || lv[6] !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold: got valid %b %b required 1 1", lv[3], lv[6]);
    end
    n_cmp++; if (pops != 4) begin n_fail++; $display("FAIL bp_pops: got %0d required 4", pops); end
  endtask

  task automatic test_starvation();
    word_t w;
    logic [NQ-1:0] acc;
    do_reset();
    out_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      w[DW-1:0] = DW'($urandom);
      w[DW]     = 1'b0;
      fq[3].push_back(w);
    end
    drive_fifos();
    repeat (6) tick();
    push_pkt(0, 2);
    repeat (6) tick();
    acc = '0;
    for (int k = 6; k < 12; k++) acc |= lrd[k];
    n_cmp++; if (acc[0] !== 1'b0) begin n_fail++; $display("FAIL starve_q0_read: got %b required bit0 clear", acc); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL starve_busy: got %b required 1", busy); end
    n_cmp++; if (reads != 2) begin n_fail++; $display("FAIL starve_reads: got %0d required 2", reads); end
    push_pkt(3, 1);
    repeat (10) tick();
    n_cmp++;
    if (lrd[12] !== 4'b1000 || lrd[13] !== 4'b0001) begin
      n_fail++; $display("FAIL starve_handover: got %b %b required 1000 0001", lrd[12], lrd[13]);
    end
    n_cmp++; if (pops != 5) begin n_fail++; $display("FAIL starve_pops: got %0d required 5", pops); end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_rdy = 1'b1;
    push_pkt(2, 6);
    repeat (3) tick();
    #3;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid: got %b required 1", out_valid); end
    reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b required 0", out_valid); end
    n_cmp++; if (in_rd_en !== '0) begin n_fail++; $display("FAIL arst_rd_en: got %b required 0", in_rd_en); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b required 0", busy); end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_logs();
    push_pkt(3, 1);
    push_pkt(0, 1);
    repeat (6) tick();
    n_cmp++;
    if (lrd[0] !== 4'b0001 || lrd[1] !== 4'b1000) begin
      n_fail++; $display("FAIL arst_regrant: got %b %b required 0001 1000", lrd[0], lrd[1]);
    end
    n_cmp++; if (pops != 2) begin n_fail++; $display("FAIL arst_pops: got %0d required 2", pops); end
  endtask

  task automatic test_random();
    int pushed;
    int guard;
    bit pending;
    do_reset();
    pushed = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        int len;
        len = $urandom_range(1, 5);
        push_pkt($urandom_range(0, NQ - 1), len);
        pushed += len;
      end
      out_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    out_rdy = 1'b1;
    guard   = 0;
    pending = 1'b1;
    while (pending && guard < 400) begin
      tick();
      guard++;
      pending = (sb.size() != 0) || out_valid;
      for (int i = 0; i < NQ; i++) if (fq[i].size() != 0) pending = 1'b1;
    end
    n_cmp++; if (pending) begin n_fail++; $display("FAIL rand_drain: got not drained after %0d cycles required drained", guard); end
    n_cmp++; if (pops != pushed) begin n_fail++; $display("FAIL rand_count: got %0d words required %0d", pops, pushed); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit required completion");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    out_rdy  = 1'b0;
    in_empty = '1;
    in_dout  = '0;
    #1;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_starvation();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
